// File: rtl/prog_sender.sv
// Streams 16-bit words from memory over an 8N1 UART line (high byte first), then a 0x7fff terminator.
// Optional abort guard against an early terminator match: define PROG_SENDER_GUARD_EN.
module prog_sender #(
  parameter int CLOCK_HZ = 27_000_000,
  parameter int BAUD     = 115200,
  parameter int AW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] num_words,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [15:0]   mem_data,
  output logic          tx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int BIT_CYCLES = CLOCK_HZ / BAUD;
  localparam int BCW        = $clog2(BIT_CYCLES + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_CHECK,
    S_SEND_HI,
    S_SEND_LO,
    S_TERM_HI,
    S_TERM_LO,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [AW-1:0]   r_memAddr;
  logic [AW-1:0]   r_remaining;
  logic [AW-1:0]   w_remDec;
  logic [15:0]     r_word;
  logic            r_loaded;
  logic            w_load;
  logic [7:0]      w_loadByte;
  logic            w_guardTrip;
  logic            w_wordSent;

  logic            r_serBusy;
  logic [9:0]      r_shift;
  logic [3:0]      r_bitCnt;
  logic [BCW-1:0]  r_baudCnt;
  logic            w_serReady;

  assign w_serReady = !r_serBusy;
  assign tx         = r_serBusy ? r_shift[0] : 1'b1;
  assign mem_addr   = r_memAddr;
  assign w_remDec   = r_remaining - AW'(1);
  assign w_wordSent = (r_state == S_SEND_LO) && w_serReady && r_loaded;

  // Frame is {stop, data, start}, shifted out LSB first; async reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_serBusy <= 1'b0;
      r_shift   <= '1;
      r_bitCnt  <= '0;
      r_baudCnt <= '0;
    end else if (!r_serBusy) begin
      if (w_load) begin
        r_shift   <= {1'b1, w_loadByte, 1'b0};
        r_serBusy <= 1'b1;
        r_bitCnt  <= '0;
        r_baudCnt <= '0;
      end
    end else if (r_baudCnt == BIT_LAST) begin
      r_baudCnt <= '0;
      if (r_bitCnt == 4'd9) begin
        r_serBusy <= 1'b0;
      end else begin
        r_bitCnt <= r_bitCnt + 4'd1;
        r_shift  <= {1'b1, r_shift[9:1]};
      end
    end else begin
      r_baudCnt <= r_baudCnt + BCW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_stateNext;
  end

  // Send states first queue their own byte, then on the next ready queue the follow-on byte and advance.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:    if (start) w_stateNext = (num_words == '0) ? S_TERM_HI : S_FETCH;
      S_FETCH:   w_stateNext = S_CAPT;
      S_CAPT:    w_stateNext = S_CHECK;
      S_CHECK:   w_stateNext = w_guardTrip ? S_TERM_HI : S_SEND_HI;
      S_SEND_HI: if (w_serReady && r_loaded) w_stateNext = S_SEND_LO;
      S_SEND_LO: if (w_wordSent) w_stateNext = (w_remDec == '0) ? S_TERM_HI : S_FETCH;
      S_TERM_HI: if (w_serReady && r_loaded) w_stateNext = S_TERM_LO;
      S_TERM_LO: if (w_serReady && r_loaded) w_stateNext = S_DONE;
      S_DONE:    w_stateNext = S_IDLE;
      default:   w_stateNext = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd     = (r_state == S_FETCH);
    done       = (r_state == S_DONE);
    busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    w_load     = 1'b0;
    w_loadByte = 8'h00;
    case (r_state)
      S_SEND_HI: begin
        w_load     = w_serReady;
        w_loadByte = r_loaded ? r_word[7:0] : r_word[15:8];
      end
      S_TERM_HI: begin
        w_load     = w_serReady;
        w_loadByte = r_loaded ? 8'hff : 8'h7f;
      end
      default: begin
        w_load     = 1'b0;
        w_loadByte = 8'h00;
      end
    endcase
  end

  // r_loaded tracks whether the byte owned by the current state is already queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_memAddr   <= '0;
      r_remaining <= '0;
      r_word      <= '0;
      r_loaded    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_memAddr   <= base_addr;
        r_remaining <= num_words;
      end
      if (r_state == S_CAPT) r_word <= mem_data;
      if (w_wordSent) begin
        r_memAddr   <= r_memAddr + AW'(2);
        r_remaining <= w_remDec;
      end
      if (r_state != w_stateNext) r_loaded <= w_load;
      else if (w_load)            r_loaded <= 1'b1;
    end
  end

`ifdef PROG_SENDER_GUARD_EN
  logic       r_err;
  logic [7:0] r_prevLo;

  assign w_guardTrip = (r_word == 16'h7fff) || ((r_prevLo == 8'h7f) && (r_word[15:8] == 8'hff));
  assign err         = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_prevLo <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_err    <= 1'b0;
        r_prevLo <= '0;
      end
      if (r_state == S_CHECK && w_guardTrip) r_err <= 1'b1;
      if (w_wordSent) r_prevLo <= r_word[7:0];
    end
  end
`else
  assign w_guardTrip = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sender.sv
// Directed bench for prog_sender: decodes the UART line and checks bytes, timing and status outputs.
module tb_prog_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  baseAddr;
  logic [9:0]  numWords;
  logic [9:0]  memAddr;
  logic        memRd;
  logic [15:0] memData = '0;
  logic        tx;
  logic        busy;
  logic        done;
  logic        err;

  logic [15:0] mem [0:511];

  int          cyc = 0;
  int          startCyc = 0;
  int          passChecks = 0;
  int          failChecks = 0;
  int          totalChecks = 0;

  logic        monClear = 1'b0;
  bit          monBusy = 1'b0;
  int          monCnt = 0;
  logic [7:0]  monByte = '0;
  logic [63:0] rxStream = '0;
  int          rxCount = 0;
  int          frameErrs = 0;
  int          doneCount = 0;
  int          memRdCount = 0;
  int          firstLowCyc = -1;

  prog_sender #(
    .CLOCK_HZ(1_000_000),
    .BAUD    (100_000),
    .AW      (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(baseAddr),
    .num_words(numWords),
    .mem_addr (memAddr),
    .mem_rd   (memRd),
    .mem_data (memData),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Word memory with one cycle of read latency.
  always @(posedge clk) begin
    if (memRd) memData <= mem[memAddr[9:1]];
  end

  // UART decoder: samples each bit at its centre, 10 cycles per bit.
  always @(negedge clk) begin
    if (rst || monClear) begin
      monBusy     = 1'b0;
      monCnt      = 0;
      rxStream    = '0;
      rxCount     = 0;
      frameErrs   = 0;
      doneCount   = 0;
      memRdCount  = 0;
      firstLowCyc = -1;
    end else begin
      if (done === 1'b1)  doneCount++;
      if (memRd === 1'b1) memRdCount++;
      if (!monBusy) begin
        if (tx === 1'b0) begin
          monBusy = 1'b1;
          monCnt  = 0;
          if (firstLowCyc < 0) firstLowCyc = cyc;
        end
      end else begin
        monCnt++;
        if (monCnt >= 15 && monCnt <= 85 && (monCnt % 10) == 5) monByte = {tx, monByte[7:1]};
        if (monCnt == 95) begin
          if (tx !== 1'b1) frameErrs++;
          rxStream = {rxStream[55:0], monByte};
          rxCount++;
          monBusy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    assert (observed === expected) passChecks++;
    else begin
      failChecks++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] base, input logic [9:0] n);
    @(posedge clk);
    #1;
    baseAddr = base;
    numWords = n;
    start    = 1'b1;
    startCyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic clearMonitor();
    @(posedge clk);
    #1 monClear = 1'b1;
    @(negedge clk);
    #1 monClear = 1'b0;
  endtask

  task automatic waitDone(output bit ok, output int dCyc);
    int i;
    ok   = 1'b0;
    dCyc = -1;
    i    = 0;
    while (!ok && i < 5000) begin
      @(negedge clk);
      i++;
      if (done === 1'b1) begin
        ok   = 1'b1;
        dCyc = cyc;
      end
    end
  endtask

  task automatic checkTransfer(input string tag, input int expFirst, input int expLat,
                               input int expCount, input logic [63:0] expStream,
                               input logic expErr, input int expRd, input logic [9:0] expAddr);
    bit ok;
    int dCyc;
    checkOutput({tag, "_busyAfterStart"}, busy, 1);
    waitDone(ok, dCyc);
    checkOutput({tag, "_doneSeen"}, ok, 1);
    checkOutput({tag, "_busyAtDone"}, busy, 0);
    checkOutput({tag, "_doneLatency"}, dCyc - startCyc, expLat);
    repeat (5) @(negedge clk);
    checkOutput({tag, "_doneCount"}, doneCount, 1);
    checkOutput({tag, "_byteCount"}, rxCount, expCount);
    checkOutput({tag, "_stream"}, rxStream, expStream);
    checkOutput({tag, "_frameErrs"}, frameErrs, 0);
    checkOutput({tag, "_firstStartBit"}, firstLowCyc - startCyc, expFirst);
    checkOutput({tag, "_err"}, err, expErr);
    checkOutput({tag, "_memRdCount"}, memRdCount, expRd);
    checkOutput({tag, "_memAddr"}, memAddr, expAddr);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[10'h300 >> 1] = 16'h1234;
    mem[10'h302 >> 1] = 16'habcd;
    mem[10'h100 >> 1] = 16'h5555;
    mem[10'h200 >> 1] = 16'h007f;
    mem[10'h202 >> 1] = 16'hff00;
    mem[10'h280 >> 1] = 16'h7fff;
    mem[10'h282 >> 1] = 16'h1234;

    rst      = 1'b1;
    start    = 1'b0;
    baseAddr = '0;
    numWords = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("resetIdle", {tx, busy, done, err, memAddr}, {1'b1, 1'b0, 1'b0, 1'b0, 10'h000});
    end

    // Two words: each word costs 206 cycles, terminator plus done adds 204.
    clearMonitor();
    applyStimulus(10'h300, 10'd2);
    checkTransfer("basic", 5, 616, 6, 64'h1234abcd7fff, 1'b0, 2, 10'h304);

    clearMonitor();
    applyStimulus(10'h010, 10'd0);
    checkTransfer("empty", 2, 204, 2, 64'h7fff, 1'b0, 0, 10'h010);

    clearMonitor();
    applyStimulus(10'h300, 10'd2);
    repeat (300) @(posedge clk);
    #1;
    baseAddr = 10'h100;
    numWords = 10'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    baseAddr = 10'h300;
    numWords = 10'd2;
    checkTransfer("startWhileBusy", 5, 616, 6, 64'h1234abcd7fff, 1'b0, 2, 10'h304);

`ifdef PROG_SENDER_GUARD_EN
    clearMonitor();
    applyStimulus(10'h200, 10'd2);
    checkTransfer("guardMisaligned", 5, 413, 4, 64'h007f7fff, 1'b1, 2, 10'h202);

    clearMonitor();
    applyStimulus(10'h280, 10'd2);
    checkTransfer("guardWord7fff", 5, 207, 2, 64'h7fff, 1'b1, 1, 10'h280);
`else
    clearMonitor();
    applyStimulus(10'h200, 10'd2);
    checkTransfer("noGuardMisaligned", 5, 616, 6, 64'h007fff007fff, 1'b0, 2, 10'h204);

    clearMonitor();
    applyStimulus(10'h280, 10'd2);
    checkTransfer("noGuardWord7fff", 5, 616, 6, 64'h7fff12347fff, 1'b0, 2, 10'h284);
`endif

    // Cycle 150 after start falls in data bit 3 of 0x34, which is a 0 on the line.
    clearMonitor();
    applyStimulus(10'h300, 10'd2);
    repeat (149) @(posedge clk);
    #2;
    checkOutput("midByte_txLowBeforeReset", tx, 0);
    rst = 1'b1;
    #1;
    checkOutput("midByte_txHighOnReset", tx, 1);
    checkOutput("midByte_busyOnReset", busy, 0);
    checkOutput("midByte_addrOnReset", memAddr, 10'h000);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    clearMonitor();
    applyStimulus(10'h300, 10'd2);
    checkTransfer("afterReset", 5, 616, 6, 64'h1234abcd7fff, 1'b0, 2, 10'h304);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
